// File: rtl/cp0_exc_sequencer_pkg.sv
// CP0 definitions shared by the exception sequencer: register indices,
// Status/Cause field positions and the sequencer state encoding.
package cp0def;

    localparam int REG_BADVADDR = 8;
    localparam int REG_STATUS   = 12;
    localparam int REG_CAUSE    = 13;
    localparam int REG_EPC      = 14;

    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_EXC_HI   = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_BADV   = 3'd3,
        ST_W_STATUS = 3'd4,
        ST_E_STATUS = 3'd5,
        ST_REDIRECT = 3'd6
    } seq_state_t;

endpackage

// File: rtl/cp0_exc_sequencer.sv
// CP0 write-port sequencer: shares the single CP0 write port between WB MTC0
// writes and hardware exception-entry / ERET register updates.
// Optional macro CP0_SEQ_BADVADDR_EN adds the BadVAddr write on exception entry.
// Handshake: none; exc_valid/eret_valid are single-cycle requests sampled only
// in IDLE, and stall_o holds the pipeline until the REDIRECT flush cycle.
module cp0_exc_sequencer
    import cp0def::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic [DATA_W-1:0] exc_pc,
    input  logic              exc_in_delay,
    input  logic              exc_has_badvaddr,
    input  logic [DATA_W-1:0] exc_badvaddr,
    input  logic              eret_valid,
    input  logic              wb_cp0_write_en,
    input  logic [ADDR_W-1:0] wb_cp0_write_addr,
    input  logic [DATA_W-1:0] wb_cp0_write_data,
    input  logic [DATA_W-1:0] cp0_status_i,
    input  logic [DATA_W-1:0] cp0_cause_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    output logic              cp0_write_en,
    output logic [ADDR_W-1:0] cp0_write_addr,
    output logic [DATA_W-1:0] cp0_write_data,
    output logic              stall_o,
    output logic              flush_o,
    output logic [DATA_W-1:0] redirect_pc_o,
    output logic              busy_o
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_epc;
    logic [DATA_W-1:0] r_cause;
    logic [DATA_W-1:0] r_status;
    logic [DATA_W-1:0] r_pc;
    logic              r_is_eret;
`ifdef CP0_SEQ_BADVADDR_EN
    logic [DATA_W-1:0] r_vaddr;
    logic              r_flag;
`else
    logic              w_unused_badv;
    assign w_unused_badv = ^{exc_has_badvaddr, exc_badvaddr};
`endif

    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_cause;
    logic [DATA_W-1:0] w_epc;
    logic [DATA_W-1:0] w_cause_cap;
    logic              w_nested;

    // Forward a same-cycle WB MTC0 into the values seen by the capture logic
    always_comb begin
        w_status = cp0_status_i;
        w_cause  = cp0_cause_i;
        w_epc    = cp0_epc_i;
        if (wb_cp0_write_en && wb_cp0_write_addr == ADDR_W'(REG_STATUS)) w_status = wb_cp0_write_data;
        if (wb_cp0_write_en && wb_cp0_write_addr == ADDR_W'(REG_CAUSE))  w_cause  = wb_cp0_write_data;
        if (wb_cp0_write_en && wb_cp0_write_addr == ADDR_W'(REG_EPC))    w_epc    = wb_cp0_write_data;
        w_nested    = w_status[STATUS_EXL_BIT];
        w_cause_cap = w_cause;
        // A nested exception keeps the BD bit that belongs to the unchanged EPC
        if (!w_nested) w_cause_cap[CAUSE_BD_BIT] = exc_in_delay;
        w_cause_cap[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Capture exception / ERET context in IDLE; exception takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc     <= '0;
            r_cause   <= '0;
            r_status  <= '0;
            r_pc      <= '0;
            r_is_eret <= 1'b0;
`ifdef CP0_SEQ_BADVADDR_EN
            r_vaddr   <= '0;
            r_flag    <= 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            if (exc_valid) begin
                r_epc     <= exc_in_delay ? exc_pc - DATA_W'(4) : exc_pc;
                r_cause   <= w_cause_cap;
                r_status  <= w_status | DATA_W'(2);
                r_is_eret <= 1'b0;
`ifdef CP0_SEQ_BADVADDR_EN
                r_vaddr   <= exc_badvaddr;
                r_flag    <= exc_has_badvaddr;
`endif
            end else if (eret_valid) begin
                r_status  <= w_status & ~DATA_W'(2);
                r_pc      <= w_epc;
                r_is_eret <= 1'b1;
            end
        end
    end

    // Next state and write-port / pipeline-control outputs
    always_comb begin
        w_state_nxt    = r_state;
        cp0_write_en   = 1'b0;
        cp0_write_addr = '0;
        cp0_write_data = '0;
        stall_o        = 1'b1;
        flush_o        = 1'b0;
        redirect_pc_o  = '0;
        busy_o         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                cp0_write_en   = wb_cp0_write_en;
                cp0_write_addr = wb_cp0_write_addr;
                cp0_write_data = wb_cp0_write_data;
                stall_o        = exc_valid | eret_valid;
                if (exc_valid)       w_state_nxt = w_nested ? ST_W_CAUSE : ST_W_EPC;
                else if (eret_valid) w_state_nxt = ST_E_STATUS;
            end
            ST_W_EPC: begin
                cp0_write_en   = 1'b1;
                cp0_write_addr = ADDR_W'(REG_EPC);
                cp0_write_data = r_epc;
                w_state_nxt    = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                cp0_write_en   = 1'b1;
                cp0_write_addr = ADDR_W'(REG_CAUSE);
                cp0_write_data = r_cause;
`ifdef CP0_SEQ_BADVADDR_EN
                w_state_nxt    = r_flag ? ST_W_BADV : ST_W_STATUS;
`else
                w_state_nxt    = ST_W_STATUS;
`endif
            end
`ifdef CP0_SEQ_BADVADDR_EN
            ST_W_BADV: begin
                cp0_write_en   = 1'b1;
                cp0_write_addr = ADDR_W'(REG_BADVADDR);
                cp0_write_data = r_vaddr;
                w_state_nxt    = ST_W_STATUS;
            end
`endif
            ST_W_STATUS, ST_E_STATUS: begin
                cp0_write_en   = 1'b1;
                cp0_write_addr = ADDR_W'(REG_STATUS);
                cp0_write_data = r_status;
                w_state_nxt    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                stall_o       = 1'b0;
                flush_o       = 1'b1;
                redirect_pc_o = r_is_eret ? r_pc : EXC_VECTOR;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                stall_o     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Outputs read as zero for as long as reset is asserted
        if (!rst_n) begin
            cp0_write_en   = 1'b0;
            cp0_write_addr = '0;
            cp0_write_data = '0;
            stall_o        = 1'b0;
            flush_o        = 1'b0;
            redirect_pc_o  = '0;
            busy_o         = 1'b0;
        end
    end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Self-checking bench for cp0_exc_sequencer: directed cases plus randomized
// transactions scored against a register-update list built from the CP0 rules.
module tb_cp0_exc_sequencer;

    localparam int          DW      = 32;
    localparam int          AW      = 5;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int          R_BADV  = 8;
    localparam int          R_STAT  = 12;
    localparam int          R_CAUSE = 13;
    localparam int          R_EPC   = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          exc_valid = 1'b0;
    logic [4:0]    exc_code = '0;
    logic [DW-1:0] exc_pc = '0;
    logic          exc_in_delay = 1'b0;
    logic          exc_has_badvaddr = 1'b0;
    logic [DW-1:0] exc_badvaddr = '0;
    logic          eret_valid = 1'b0;
    logic          wb_cp0_write_en = 1'b0;
    logic [AW-1:0] wb_cp0_write_addr = '0;
    logic [DW-1:0] wb_cp0_write_data = '0;
    logic [DW-1:0] cp0_status_i = '0;
    logic [DW-1:0] cp0_cause_i = '0;
    logic [DW-1:0] cp0_epc_i = '0;
    logic          cp0_write_en;
    logic [AW-1:0] cp0_write_addr;
    logic [DW-1:0] cp0_write_data;
    logic          stall_o;
    logic          flush_o;
    logic [DW-1:0] redirect_pc_o;
    logic          busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    exp_redirect;

    cp0_exc_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exc_valid         (exc_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay      (exc_in_delay),
        .exc_has_badvaddr  (exc_has_badvaddr),
        .exc_badvaddr      (exc_badvaddr),
        .eret_valid        (eret_valid),
        .wb_cp0_write_en   (wb_cp0_write_en),
        .wb_cp0_write_addr (wb_cp0_write_addr),
        .wb_cp0_write_data (wb_cp0_write_data),
        .cp0_status_i      (cp0_status_i),
        .cp0_cause_i       (cp0_cause_i),
        .cp0_epc_i         (cp0_epc_i),
        .cp0_write_en      (cp0_write_en),
        .cp0_write_addr    (cp0_write_addr),
        .cp0_write_data    (cp0_write_data),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .redirect_pc_o     (redirect_pc_o),
        .busy_o            (busy_o)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: list of CP0 register updates and the redirect target
    task automatic build_model(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                               input logic dly, input logic hasb, input logic [31:0] badv,
                               input logic eret, input logic wen, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [31:0] st,
                               input logic [31:0] ca, input logic [31:0] ep);
        logic [31:0] fs, fc, fe, nc;
        fs = (wen && waddr == 5'(R_STAT))  ? wdata : st;
        fc = (wen && waddr == 5'(R_CAUSE)) ? wdata : ca;
        fe = (wen && waddr == 5'(R_EPC))   ? wdata : ep;
        exp_q.delete();
        exp_redirect = '0;
        if (exc) begin
            nc = fc;
            if (fs[1] == 1'b0) begin
                exp_q.push_back({5'(R_EPC), dly ? pc - 32'd4 : pc});
                nc[31] = dly;
            end
            nc = (nc & ~32'h7C) | ({27'd0, code} << 2);
            exp_q.push_back({5'(R_CAUSE), nc});
`ifdef CP0_SEQ_BADVADDR_EN
            if (hasb) exp_q.push_back({5'(R_BADV), badv});
`else
            if (hasb && badv == 32'h0) exp_redirect = '0;
`endif
            exp_q.push_back({5'(R_STAT), fs | 32'h2});
            exp_redirect = EXC_VEC;
        end else if (eret) begin
            exp_q.push_back({5'(R_STAT), fs & ~32'h2});
            exp_redirect = fe;
        end
    endtask

    // Driver: present one request for a capture cycle, then score the sequence
    task automatic run_txn(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                           input logic dly, input logic hasb, input logic [31:0] badv,
                           input logic eret, input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep);
        logic [AW+DW-1:0] e;
        int n_wr;
        bit done;
        @(negedge clk);
        exc_valid = exc; exc_code = code; exc_pc = pc; exc_in_delay = dly;
        exc_has_badvaddr = hasb; exc_badvaddr = badv; eret_valid = eret;
        wb_cp0_write_en = wen; wb_cp0_write_addr = waddr; wb_cp0_write_data = wdata;
        cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
        build_model(exc, code, pc, dly, hasb, badv, eret, wen, waddr, wdata, st, ca, ep);
        n_wr = exp_q.size();
        #1;
        chk("pt_en", cp0_write_en, wen);
        if (wen) begin
            chk("pt_addr", cp0_write_addr, waddr);
            chk("pt_data", cp0_write_data, wdata);
        end
        chk("stall_cap", stall_o, exc | eret);
        @(posedge clk);
        #1;
        exc_valid = 0; eret_valid = 0; wb_cp0_write_en = 0; wb_cp0_write_addr = '0;
        wb_cp0_write_data = '0; exc_has_badvaddr = 0;
        cp0_status_i = $urandom; cp0_cause_i = $urandom; cp0_epc_i = $urandom;
        if (!exc && !eret) begin
            @(negedge clk);
            chk("idle_busy", busy_o, 0);
            chk("idle_wr", cp0_write_en, 0);
            return;
        end
        done = 0;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            chk("busy", busy_o, 1);
            if (cp0_write_en) begin
                if (exp_q.size() == 0) chk("extra_wr", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", cp0_write_addr, e[AW+DW-1:DW]);
                    chk("wr_data", cp0_write_data, e[DW-1:0]);
                end
            end
            if (flush_o) begin
                chk("rd_pc", redirect_pc_o, exp_redirect);
                chk("flush_lat", k, n_wr + 1);
                chk("stall_rd", stall_o, 0);
                chk("wr_left", exp_q.size(), 0);
                done = 1;
            end else begin
                chk("stall", stall_o, 1);
            end
        end
        if (!done) chk("timeout", 0, 1);
        @(negedge clk);
        chk("flush_1cyc", flush_o, 0);
        chk("idle_again", busy_o, 0);
    endtask

    // Stimulus and final report
    initial begin
        logic [1:0]  sel;
        logic [4:0]  wa;
        logic [31:0] st;
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_wr", cp0_write_en, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_stall", stall_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic exception, then delay-slot exception, nested, ERET, forwarded EPC
        run_txn(1, 5'd4, 32'h80001000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        run_txn(1, 5'd4, 32'h80001000, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        run_txn(1, 5'd8, 32'h80001234, 1, 0, 0, 0, 0, 0, 0, 32'h3, 32'h0, 32'h0);
        run_txn(0, 5'd0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h3, 32'h0, 32'h80002000);
        run_txn(0, 5'd0, 32'h0, 0, 0, 0, 1, 1, 5'd14, 32'h12345678, 32'h3, 32'h0, 32'h80002000);
        run_txn(1, 5'd12, 32'h80003000, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h80000000, 32'h0);
        run_txn(1, 5'd5, 32'h80004000, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0);

        // reset asserted while the Cause write is on the port
        @(negedge clk);
        exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h80001000; cp0_status_i = 32'h0;
        @(posedge clk);
        #1 exc_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_wr", cp0_write_en, 1);
        chk("pre_rst_addr", cp0_write_addr, R_CAUSE);
        rst_n = 1'b0;
        #1;
        chk("arst_wr", cp0_write_en, 0);
        chk("arst_addr", cp0_write_addr, 0);
        chk("arst_data", cp0_write_data, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_flush", flush_o, 0);

        // randomized transactions
        for (int i = 0; i < 80; i++) begin
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: wa = 5'(R_STAT);
                1: wa = 5'(R_CAUSE);
                2: wa = 5'(R_EPC);
                3: wa = 5'(R_BADV);
                default: wa = 5'($urandom_range(0, 31));
            endcase
            st = $urandom;
            run_txn(sel == 2'd0 || sel == 2'd2, 5'($urandom_range(0, 31)),
                    {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom,
                    sel == 2'd1 || sel == 2'd2, 1'($urandom_range(0, 1)), wa, $urandom,
                    st, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
